// File: rtl/cp0_unit_if.sv
// CP0 <-> pipeline M-stage bundle: exception inputs, mtc0/mfc0 access,
// and the flush/redirect outputs back to the pipeline.
interface cp0_unit_if;
    logic [31:0] M_pc;
    logic        M_is_delay;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        CP0_we;
    logic [4:0]  CP0_addr;
    logic [31:0] CP0_Wdata;
    logic        M_eret;
    logic [31:0] CP0_Rdata;
    logic [31:0] EPC_out;
    logic        M_REQ;
    logic [31:0] handler_pc;

    modport master (
        output M_pc, M_is_delay, M_ExcCode, HWInt,
        output CP0_we, CP0_addr, CP0_Wdata, M_eret,
        input  CP0_Rdata, EPC_out, M_REQ, handler_pc
    );

    modport slave (
        input  M_pc, M_is_delay, M_ExcCode, HWInt,
        input  CP0_we, CP0_addr, CP0_Wdata, M_eret,
        output CP0_Rdata, EPC_out, M_REQ, handler_pc
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC, interrupt and exception entry at the M stage,
// eret handling and mfc0/mtc0 access.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic      clk,
    input  logic      rst,
    cp0_unit_if.slave bus
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] macro_pc;
    logic        macro_bd;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        wr_en;
    logic        m_valid;
    logic [31:0] epc_trap;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign m_valid = bus.M_pc != 32'd0;

    always_comb begin
        int_req = (|(bus.HWInt & im)) & ie & ~exl;
        exc_req = (bus.M_ExcCode != 5'd0) & ~exl;
        req     = rst & (int_req | exc_req);
        wr_en   = bus.CP0_we & ~req;
        // A bubble has no PC of its own, so resume after the last real one.
        if (m_valid) begin
            if (bus.M_is_delay)
                epc_trap = (bus.M_pc - 32'd4) & ~32'd3;
            else
                epc_trap = bus.M_pc & ~32'd3;
        end else begin
            if (macro_bd)
                epc_trap = macro_pc;
            else
                epc_trap = macro_pc + 32'd4;
        end
    end

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    always_comb begin
        bus.CP0_Rdata = 32'd0;
        unique case (1'b1)
            bus.CP0_addr == ADDR_SR:    bus.CP0_Rdata = sr_word;
            bus.CP0_addr == ADDR_CAUSE: bus.CP0_Rdata = cause_word;
            bus.CP0_addr == ADDR_EPC:   bus.CP0_Rdata = epc;
            default:                    bus.CP0_Rdata = 32'd0;
        endcase
    end

    assign bus.M_REQ      = req;
    assign bus.EPC_out    = epc;
    assign bus.handler_pc = HANDLER_ADDR;

    always_ff @(posedge clk) begin
        if (!rst) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
            macro_pc <= 32'd0;
            macro_bd <= 1'b0;
        end else begin
            ip <= bus.HWInt;
            if (m_valid) begin
                macro_pc <= bus.M_pc;
                macro_bd <= bus.M_is_delay;
            end
            if (req) begin
                exl      <= 1'b1;
                bd       <= m_valid & bus.M_is_delay;
                exc_code <= int_req ? 5'd0 : bus.M_ExcCode;
                epc      <= epc_trap;
            end else begin
                if (wr_en && bus.CP0_addr == ADDR_SR) begin
                    im  <= bus.CP0_Wdata[15:10];
                    exl <= bus.CP0_Wdata[1];
                    ie  <= bus.CP0_Wdata[0];
                end
                if (wr_en && bus.CP0_addr == ADDR_EPC)
                    epc <= bus.CP0_Wdata & ~32'd3;
                // eret wins over an SR write in the same cycle.
                if (bus.M_eret)
                    exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: word-level CP0 model checked every cycle,
// plus literal expectations for the key exception/interrupt scenarios.
module tb_cp0_unit;

    logic clk;
    logic rst;
    int   vecs = 0;
    int   miss = 0;

    cp0_unit_if bus ();

    cp0_unit #(.HANDLER_ADDR(32'h0000_4180)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: whole register words, masked to their legal fields.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;
    logic [31:0] m_mpc   = 32'd0;
    logic        m_mbd   = 1'b0;

    function automatic logic m_irq();
        return (|(bus.HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        logic exc;
        exc = (bus.M_ExcCode != 5'd0) && !m_sr[1];
        return rst && (m_irq() || exc);
    endfunction

    function automatic logic [31:0] m_rd();
        case (bus.CP0_addr)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic irq;
        logic req;
        if (!rst) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
            m_mpc   = 32'd0;
            m_mbd   = 1'b0;
        end else begin
            irq = m_irq();
            req = m_req();
            if (req) begin
                m_sr[1] = 1'b1;
                if (bus.M_pc != 32'd0) begin
                    m_epc = bus.M_is_delay ? bus.M_pc - 32'd4 : bus.M_pc;
                    m_epc = m_epc & 32'hffff_fffc;
                    m_cause[31] = bus.M_is_delay;
                end else begin
                    m_epc = m_mbd ? m_mpc : m_mpc + 32'd4;
                    m_cause[31] = 1'b0;
                end
                m_cause[6:2] = irq ? 5'd0 : bus.M_ExcCode;
            end else begin
                if (bus.CP0_we && bus.CP0_addr == 5'd12)
                    m_sr = bus.CP0_Wdata & 32'h0000_fc03;
                if (bus.CP0_we && bus.CP0_addr == 5'd14)
                    m_epc = bus.CP0_Wdata & 32'hffff_fffc;
                if (bus.M_eret)
                    m_sr[1] = 1'b0;
            end
            m_cause[15:10] = bus.HWInt;
            if (bus.M_pc != 32'd0) begin
                m_mpc = bus.M_pc;
                m_mbd = bus.M_is_delay;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("M_REQ", {31'd0, bus.M_REQ}, {31'd0, m_req()});
        chk("EPC_out", bus.EPC_out, m_epc);
        chk("Rdata", bus.CP0_Rdata, m_rd());
        chk("handler", bus.handler_pc, 32'h0000_4180);
    end

    task automatic vec(input logic r, input logic [31:0] pc,
                       input logic d, input logic [4:0] c,
                       input logic [5:0] h, input logic w,
                       input logic [4:0] a, input logic [31:0] wd,
                       input logic e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.M_pc      = pc;
        bus.M_is_delay= d;
        bus.M_ExcCode = c;
        bus.HWInt     = h;
        bus.CP0_we    = w;
        bus.CP0_addr  = a;
        bus.CP0_Wdata = wd;
        bus.M_eret    = e;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] a);
        vec(1, 0, 0, 0, 0, 0, a, 0, 0);
    endtask

    task automatic eret();
        vec(1, 0, 0, 0, 0, 0, 5'd12, 0, 1);
        idle(5'd12);
    endtask

    initial begin
        rst            = 1'b0;
        bus.M_pc       = 32'd0;
        bus.M_is_delay = 1'b0;
        bus.M_ExcCode  = 5'd0;
        bus.HWInt      = 6'd0;
        bus.CP0_we     = 1'b0;
        bus.CP0_addr   = 5'd0;
        bus.CP0_Wdata  = 32'd0;
        bus.M_eret     = 1'b0;

        vec(0, 0, 0, 0, 0, 0, 5'd12, 0, 0);
        chk("rst_sr", bus.CP0_Rdata, 32'd0);
        chk("rst_req", {31'd0, bus.M_REQ}, 32'd0);
        idle(5'd13);
        chk("rst_cause", bus.CP0_Rdata, 32'd0);

        // Interrupt on a real instruction.
        vec(1, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0401, 0);
        vec(1, 32'h3008, 0, 0, 6'd1, 0, 5'd13, 0, 0);
        chk("int_req", {31'd0, bus.M_REQ}, 32'd1);
        idle(5'd13);
        chk("int_epc", bus.EPC_out, 32'h3008);
        chk("int_cause", bus.CP0_Rdata, 32'h0000_0400);
        vec(1, 0, 0, 0, 0, 0, 5'd12, 0, 1);
        chk("int_exl", bus.CP0_Rdata, 32'h0000_0403);
        idle(5'd12);
        chk("eret_sr", bus.CP0_Rdata, 32'h0000_0401);

        // Exception in a delay slot.
        vec(1, 32'h3010, 1, 5'd12, 0, 0, 5'd13, 0, 0);
        chk("exc_req", {31'd0, bus.M_REQ}, 32'd1);
        idle(5'd13);
        chk("exc_epc", bus.EPC_out, 32'h300C);
        chk("exc_cause", bus.CP0_Rdata, 32'h8000_0030);

        // Masked by EXL, then eret.
        vec(1, 32'h3018, 0, 5'd10, 0, 0, 5'd14, 0, 0);
        chk("exl_mask", {31'd0, bus.M_REQ}, 32'd0);
        vec(1, 0, 0, 0, 0, 0, 5'd12, 0, 1);
        chk("exl_epc", bus.EPC_out, 32'h300C);
        chk("exl_sr", bus.CP0_Rdata, 32'h0000_0403);
        idle(5'd12);
        chk("exl_clr", bus.CP0_Rdata, 32'h0000_0401);

        // Interrupt on a bubble.
        vec(1, 32'h3020, 0, 0, 0, 0, 5'd13, 0, 0);
        vec(1, 0, 0, 0, 6'd1, 0, 5'd13, 0, 0);
        chk("bub_req", {31'd0, bus.M_REQ}, 32'd1);
        idle(5'd13);
        chk("bub_epc", bus.EPC_out, 32'h3024);
        chk("bub_cause", bus.CP0_Rdata, 32'h0000_0400);
        eret();

        // mtc0 EPC colliding with an exception.
        vec(1, 32'h3040, 0, 5'd4, 0, 1, 5'd14, 32'h3047, 0);
        chk("col_req", {31'd0, bus.M_REQ}, 32'd1);
        idle(5'd13);
        chk("col_epc", bus.EPC_out, 32'h3040);
        chk("col_cause", bus.CP0_Rdata, 32'h0000_0010);
        eret();

        // Plain writes, ignored Cause write, eret over SR write.
        vec(1, 0, 0, 0, 0, 1, 5'd14, 32'h1237, 0);
        idle(5'd14);
        chk("wr_epc", bus.CP0_Rdata, 32'h1234);
        vec(1, 0, 0, 0, 0, 1, 5'd13, 32'hffff_ffff, 0);
        idle(5'd13);
        chk("wr_cause", bus.CP0_Rdata, 32'h0000_0010);
        vec(1, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0403, 1);
        idle(5'd12);
        chk("eret_wr", bus.CP0_Rdata, 32'h0000_0401);

        // Interrupt gating by IE and IM.
        vec(1, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0400, 0);
        vec(1, 32'h3060, 0, 0, 6'd1, 0, 5'd12, 0, 0);
        chk("ie_mask", {31'd0, bus.M_REQ}, 32'd0);
        vec(1, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0801, 0);
        vec(1, 32'h3064, 0, 0, 6'd1, 0, 5'd12, 0, 0);
        chk("im_mask", {31'd0, bus.M_REQ}, 32'd0);
        vec(1, 32'h3068, 1, 0, 6'd2, 0, 5'd12, 0, 0);
        chk("im_hit", {31'd0, bus.M_REQ}, 32'd1);
        idle(5'd14);
        chk("im_epc", bus.CP0_Rdata, 32'h3064);

        // Reset while EXL=1 with an exception pending.
        vec(0, 32'h3050, 0, 5'd5, 6'd2, 0, 5'd12, 0, 0);
        chk("rst_mid_req", {31'd0, bus.M_REQ}, 32'd0);
        idle(5'd12);
        chk("rst_mid_sr", bus.CP0_Rdata, 32'd0);
        chk("rst_mid_epc", bus.EPC_out, 32'd0);
        idle(5'd13);
        chk("rst_mid_cause", bus.CP0_Rdata, 32'd0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
